// File: rtl/register_file_if.sv
// Bus between the CPU datapath and the architectural register file.
// Groups the two read ports, the write port and the flag-update signals.
//   master : datapath side. It drives the addresses, write data, write/flag enables and ALU Cout.
//   slave  : register file side. It returns the read data and the registered C/Z/N flags.
interface register_file_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  flag_write;
  logic                  alu_cout;
  logic                  carry_flag;
  logic                  zero_flag;
  logic                  neg_flag;

  modport master (
    output rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, flag_write, alu_cout,
    input  rs1_data, rs2_data, carry_flag, zero_flag, neg_flag
  );

  modport slave (
    input  rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, flag_write, alu_cout,
    output rs1_data, rs2_data, carry_flag, zero_flag, neg_flag
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file and C/Z/N status-flag register for the
// single-cycle CPU. It sits directly upstream of the ALU.
//
// The block has two combinational read ports with same-cycle write bypass and
// one synchronous write port. The flag register captures ALU Cout and the
// zero/sign state of the writeback data.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high. It clears all registers and flags and wins over any write.
//   bus   : register_file_if.slave. It carries the following signals:
//             rs1/rs2 address and data
//             reg_write, rd_addr, rd_data
//             flag_write, alu_cout
//             carry_flag, zero_flag, neg_flag
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int R0_ZERO    = 1
) (
  input  logic               clk,
  input  logic               reset,
  register_file_if.slave     bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam bit R0_HARD  = (R0_ZERO != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // A write to a hard-wired r0 is dropped. It must not bypass either.
  logic write_en;
  assign write_en = bus.reg_write & ~(R0_HARD & (bus.rd_addr == '0));

  logic rs1_is_r0, rs2_is_r0;
  assign rs1_is_r0 = R0_HARD & (bus.rs1_addr == '0);
  assign rs2_is_r0 = R0_HARD & (bus.rs2_addr == '0);

  logic rs1_hit, rs2_hit;
  assign rs1_hit = write_en & (bus.rd_addr == bus.rs1_addr);
  assign rs2_hit = write_en & (bus.rd_addr == bus.rs2_addr);

  // Reads are not gated by reset. The bypass stays live even in a reset cycle.
  assign bus.rs1_data = rs1_is_r0 ? '0 : (rs1_hit ? bus.rd_data : regs[bus.rs1_addr]);
  assign bus.rs2_data = rs2_is_r0 ? '0 : (rs2_hit ? bus.rd_data : regs[bus.rs2_addr]);

  // ---- write-back / flag capture edge ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      bus.carry_flag <= 1'b0;
      bus.zero_flag  <= 1'b0;
      bus.neg_flag   <= 1'b0;
    end else begin
      if (write_en) begin
        regs[bus.rd_addr] <= bus.rd_data;
      end
      // Flags follow rd_data whether or not a register is written. This lets compare-type ops set flags.
      if (bus.flag_write) begin
        bus.carry_flag <= bus.alu_cout;
        bus.zero_flag  <= (bus.rd_data == '0);
        bus.neg_flag   <= bus.rd_data[DATA_WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();
  register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus0 ();

  // dut  : R0 hard-wired to zero
  // dut0 : R0 is an ordinary register. It is driven with identical stimulus.
  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .R0_ZERO(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  assign bus0.rs1_addr   = bus.rs1_addr;
  assign bus0.rs2_addr   = bus.rs2_addr;
  assign bus0.reg_write  = bus.reg_write;
  assign bus0.rd_addr    = bus.rd_addr;
  assign bus0.rd_data    = bus.rd_data;
  assign bus0.flag_write = bus.flag_write;
  assign bus0.alu_cout   = bus.alu_cout;

  typedef struct {
    logic        rst;
    logic [2:0]  r1, r2;
    logic        we;
    logic [2:0]  rd;
    logic [15:0] wd;
    logic        fw, co;
    logic [15:0] e1, e2;
    logic        ec, ez, en;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  // Reference model. Index 0 is the R0_ZERO=1 instance; index 1 is the R0_ZERO=0 instance.
  logic [15:0] m_regs [2][8];
  logic        m_c, m_z, m_n;

  function automatic vec_t mk(logic rst, logic [2:0] r1, logic [2:0] r2, logic we,
                              logic [2:0] rd, logic [15:0] wd, logic fw, logic co,
                              logic [15:0] e1, logic [15:0] e2,
                              logic ec, logic ez, logic en);
    vec_t v;
    v.rst = rst; v.r1 = r1; v.r2 = r2; v.we = we; v.rd = rd; v.wd = wd;
    v.fw = fw; v.co = co; v.e1 = e1; v.e2 = e2; v.ec = ec; v.ez = ez; v.en = en;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [2:0] r1, input logic [2:0] r2,
                       input logic we, input logic [2:0] rd, input logic [15:0] wd,
                       input logic fw, input logic co);
    reset          = rst;
    bus.rs1_addr   = r1;
    bus.rs2_addr   = r2;
    bus.reg_write  = we;
    bus.rd_addr    = rd;
    bus.rd_data    = wd;
    bus.flag_write = fw;
    bus.alu_cout   = co;
  endtask

  function automatic logic [15:0] m_read(int inst, logic [2:0] a);
    bit r0z = (inst == 0);
    if (r0z && a == 3'd0) return 16'h0000;
    if (bus.reg_write && bus.rd_addr == a) return bus.rd_data;
    return m_regs[inst][a];
  endfunction

  task automatic m_update();
    if (reset) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 8; a++) m_regs[k][a] = 16'h0000;
      m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
    end else begin
      if (bus.reg_write) begin
        if (bus.rd_addr != 3'd0) m_regs[0][bus.rd_addr] = bus.rd_data;
        m_regs[1][bus.rd_addr] = bus.rd_data;
      end
      if (bus.flag_write) begin
        m_c = bus.alu_cout;
        m_z = (bus.rd_data == 16'h0000);
        m_n = bus.rd_data[15];
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, " r0z rs1"}, bus.rs1_data,  m_read(0, bus.rs1_addr));
    chk({tag, " r0z rs2"}, bus.rs2_data,  m_read(0, bus.rs2_addr));
    chk({tag, " r0z C"},   {15'd0, bus.carry_flag}, {15'd0, m_c});
    chk({tag, " r0z Z"},   {15'd0, bus.zero_flag},  {15'd0, m_z});
    chk({tag, " r0z N"},   {15'd0, bus.neg_flag},   {15'd0, m_n});
    chk({tag, " r0n rs1"}, bus0.rs1_data, m_read(1, bus.rs1_addr));
    chk({tag, " r0n rs2"}, bus0.rs2_data, m_read(1, bus.rs2_addr));
    chk({tag, " r0n C"},   {15'd0, bus0.carry_flag}, {15'd0, m_c});
    chk({tag, " r0n Z"},   {15'd0, bus0.zero_flag},  {15'd0, m_z});
    chk({tag, " r0n N"},   {15'd0, bus0.neg_flag},   {15'd0, m_n});
  endtask

  // Clock edge: the model follows the same inputs; the next drive happens at negedge.
  task automatic edge_step();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  initial begin
    // Table of vectors. The expected outputs are sampled before the clock edge of that row.
    // Flags shown are the result of earlier edges.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 3'(i), 3'((i + 1) % 8), 1, 3'(i), 16'hFFFF, 0, 0,
                       (i == 0) ? 16'h0000 : 16'hFFFF, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 3, 7, 0, 0, 16'h0000, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 16'h0000, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 5, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 3, 5, 0, 0, 16'h0000, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 16'h0001, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 2, 2, 1, 2, 16'hA5A5, 0, 0, 16'hA5A5, 16'hA5A5, 0, 0, 0));
    tbl.push_back(mk(0, 2, 2, 0, 0, 16'h0000, 0, 0, 16'hA5A5, 16'hA5A5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 16'h7777, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h8000, 1, 1, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0001, 0, 1, 16'h0000, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 16'h1111, 1, 1, 16'h0000, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 4, 4, 1, 4, 16'h5555, 1, 1, 16'h5555, 16'h5555, 1, 0, 0));
    tbl.push_back(mk(0, 4, 4, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));

    // Initial reset. The contents are undefined beforehand, so nothing is compared here.
    drive(1, 0, 0, 0, 0, 16'h0000, 0, 0);
    @(negedge clk);
    edge_step();
    edge_step();

    foreach (tbl[i]) begin
      vec_t v = tbl[i];
      drive(v.rst, v.r1, v.r2, v.we, v.rd, v.wd, v.fw, v.co);
      #1;
      chk($sformatf("tbl%0d rs1", i), bus.rs1_data, v.e1);
      chk($sformatf("tbl%0d rs2", i), bus.rs2_data, v.e2);
      chk($sformatf("tbl%0d C", i), {15'd0, bus.carry_flag}, {15'd0, v.ec});
      chk($sformatf("tbl%0d Z", i), {15'd0, bus.zero_flag},  {15'd0, v.ez});
      chk($sformatf("tbl%0d N", i), {15'd0, bus.neg_flag},   {15'd0, v.en});
      model_check($sformatf("tbl%0d model", i));
      edge_step();
    end

    // r0 write on both instances. The hard-wired r0 stays 0.
    // The ordinary r0 bypasses the value in the same cycle and then holds it.
    drive(0, 0, 0, 1, 0, 16'h7777, 0, 0);
    #1;
    chk("r0 ordinary bypass", bus0.rs1_data, 16'h7777);
    chk("r0 hard bypass", bus.rs1_data, 16'h0000);
    edge_step();
    drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    #1;
    chk("r0 ordinary readback", bus0.rs1_data, 16'h7777);
    chk("r0 hard readback", bus.rs1_data, 16'h0000);
    model_check("r0 seq");
    edge_step();

    // Carry chaining. C is registered only; it is visible in the next cycle and not bypassed.
    drive(0, 1, 1, 1, 1, 16'h0042, 1, 1);
    #1;
    chk("carry not bypassed", {15'd0, bus.carry_flag}, 16'h0000);
    edge_step();
    drive(0, 1, 1, 0, 0, 16'h0000, 0, 0);
    #1;
    chk("carry after edge", {15'd0, bus.carry_flag}, 16'h0001);
    chk("compare-type write kept", bus.rs1_data, 16'h0042);
    edge_step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] wd;
      wd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      drive(($urandom_range(0, 31) == 0), 3'($urandom), 3'($urandom), 1'($urandom),
            3'($urandom), wd, 1'($urandom), 1'($urandom));
      #1;
      model_check($sformatf("rnd%0d", n));
      edge_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
